fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/mips_pkg.sv | 16 +
 rtl/fetch_unit_if.sv | 16 +
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_unit.sv | 63 ++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch path: word/address widths,
// default reset vector and the queued fetch-entry layout.
package mips_pkg;

   localparam int WORD_W  = 32;
   localparam int IMEM_AW = 6;
   localparam int ENTRY_W = 2 * WORD_W;

   localparam logic [WORD_W-1:0] RESET_PC_DEF = 32'h0000_0000;

   typedef struct packed {
      logic [WORD_W-1:0] pc;
      logic [WORD_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Push/pop channel between the fetch controller and its instruction queue.
interface fetch_fifo_if #(parameter int DEPTH = 4);
   import mips_pkg::*;

   logic         push;
   logic         pop;
   logic         flush;
   fetch_entry_t wdata;
   fetch_entry_t rdata;
   logic         full;
   logic         empty;

   modport ctrl (output push, pop, flush, wdata, input  rdata, full, empty);
   modport fifo (input  push, pop, flush, wdata, output rdata, full, empty);

endinterface

// File: rtl/fetch_fifo.sv
// Fall-through instruction queue: head entry is visible combinationally,
// flush clears pointers and count and overrides push/pop on the same edge.
module fetch_fifo
   import mips_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic       clk,
   input  logic       reset,
   fetch_fifo_if.fifo fifo_bus
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

   fetch_entry_t  mem_q [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [PW:0]   count_q, count_d;
   logic          do_push;
   logic          do_pop;

   assign fifo_bus.full  = (count_q == DEPTH_C);
   assign fifo_bus.empty = (count_q == '0);
   assign fifo_bus.rdata = mem_q[head_q];

   // A push into a full queue is dropped even when a pop frees a slot this edge.
   assign do_push = fifo_bus.push && !fifo_bus.full  && !fifo_bus.flush;
   assign do_pop  = fifo_bus.pop  && !fifo_bus.empty && !fifo_bus.flush;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (fifo_bus.flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (do_push) tail_d = tail_q + 1'b1;
         if (do_pop)  head_d = head_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[tail_q] <= fifo_bus.wdata;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: walks fetch_pc through a combinational instruction memory,
// buffering {pc, instr} pairs in a queue that decode drains; redirects flush it.
module fetch_unit
   import mips_pkg::*;
#(
   parameter int                DEPTH    = 4,
   parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEF
)
(
   input  logic               clk,
   input  logic               reset,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [WORD_W-1:0]  imem_instr,
   input  logic               redirect_valid,
   input  logic [WORD_W-1:0]  redirect_pc,
   output logic               out_valid,
   output logic [WORD_W-1:0]  out_instr,
   output logic [WORD_W-1:0]  out_pc,
   input  logic               out_ready
);

   fetch_fifo_if #(.DEPTH(DEPTH)) fifo_bus ();

   logic [WORD_W-1:0] fetch_pc_q, fetch_pc_d;
   logic              push_w;

   assign imem_addr = fetch_pc_q[7:2];

   // A pending redirect hides the head and blocks fetching into the stale stream.
   assign push_w    = !fifo_bus.full && !redirect_valid;
   assign out_valid = !fifo_bus.empty && !redirect_valid;
   assign out_instr = fifo_bus.rdata.instr;
   assign out_pc    = fifo_bus.rdata.pc;

   assign fifo_bus.push  = push_w;
   assign fifo_bus.pop   = out_valid && out_ready;
   assign fifo_bus.flush = redirect_valid;
   assign fifo_bus.wdata = '{pc: fetch_pc_q, instr: imem_instr};

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & ~32'h0000_0003;
      end else if (push_w) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
      end else begin
         fetch_pc_q <= fetch_pc_d;
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .fifo_bus (fifo_bus.fifo)
   );

endmodule
